dram_bank_timing_fsm: RTL and testbench

- Per-bank command/timing state machine for the DDR emulation chip model. Generalises single-bank ACT/RD/WR/PR sequencing to a parametrised bank-group × bank array with enforced tRCD/tRAS/tRP timing, BL-beat bursts and halt freeze.
- Sits between the decoded command vector and the bank storage arrays.
- Drives per-bank state, open row, burst beat tracking and illegal-command flagging.

---
 rtl/dram_bank_timing_fsm.sv | 197 +++++++++++++++++++
 tb/tb_dram_bank_timing_fsm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_timing_fsm.sv
// Per-bank ACT/RD/WR/PRE sequencer with tRCD/tRAS/tRP timing and a shared BL-beat burst.
// Each bank's state, open row and timers live in small register arrays; halt freezes all of them.
module dram_bank_timing_fsm #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int BL        = 8,
    parameter int T_RCD     = 4,
    parameter int T_RAS     = 10,
    parameter int T_RP      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         halt,
    input  logic                         cmd_act,
    input  logic                         cmd_rd,
    input  logic                         cmd_wr,
    input  logic                         cmd_pre,
    input  logic [BGWIDTH-1:0]           bg,
    input  logic [BAWIDTH-1:0]           ba,
    input  logic [ADDRWIDTH-1:0]         row,
    output logic [2:0]                   bank_state,
    output logic [ADDRWIDTH-1:0]         open_row,
    output logic                         all_idle,
    output logic                         burst_valid,
    output logic                         burst_wr,
    output logic [$clog2(BL)-1:0]        burst_beat,
    output logic [BGWIDTH+BAWIDTH-1:0]   burst_bank,
    output logic                         cmd_err
);

    localparam int BKW    = BGWIDTH + BAWIDTH;
    localparam int NBANKS = 1 << BKW;
    localparam int BEATW  = $clog2(BL);
    localparam int TMAX   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int RW     = $clog2(T_RAS + 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ACTIVATING  = 3'd1,
        S_ACTIVE      = 3'd2,
        S_READING     = 3'd3,
        S_WRITING     = 3'd4,
        S_PRECHARGING = 3'd5
    } bank_state_e;

    bank_state_e            state_q [NBANKS];
    bank_state_e            state_d [NBANKS];
    logic [ADDRWIDTH-1:0]   row_q   [NBANKS];
    logic [ADDRWIDTH-1:0]   row_d   [NBANKS];
    logic [TW-1:0]          tmr_q   [NBANKS];
    logic [TW-1:0]          tmr_d   [NBANKS];
    logic [RW-1:0]          ras_q   [NBANKS];
    logic [RW-1:0]          ras_d   [NBANKS];

    logic                   burst_valid_q, burst_valid_d;
    logic                   burst_wr_q,    burst_wr_d;
    logic [BEATW-1:0]       burst_beat_q,  burst_beat_d;
    logic [BKW-1:0]         burst_bank_q,  burst_bank_d;
    logic                   cmd_err_q,     cmd_err_d;

    logic [BKW-1:0]         bank_idx;
    logic [2:0]             n_cmd;
    logic                   any_cmd;
    logic                   single_cmd;
    bank_state_e            tgt_state;
    logic                   acc_act;
    logic                   acc_rw;
    logic                   acc_pre;

    assign bank_idx   = {bg, ba};
    assign n_cmd      = 3'(cmd_act) + 3'(cmd_rd) + 3'(cmd_wr) + 3'(cmd_pre);
    assign any_cmd    = (n_cmd != 3'd0);
    assign single_cmd = (n_cmd == 3'd1);
    assign tgt_state  = state_q[bank_idx];

    // tRAS counts the accepting edge itself, so PRE is legal once the counter reads T_RAS-1.
    assign acc_act = !halt && single_cmd && cmd_act && (tgt_state == S_IDLE);
    assign acc_rw  = !halt && single_cmd && (cmd_rd || cmd_wr) &&
                     (tgt_state == S_ACTIVE) && !burst_valid_q;
    assign acc_pre = !halt && single_cmd && cmd_pre && (tgt_state == S_ACTIVE) &&
                     (ras_q[bank_idx] >= RW'(T_RAS - 1));

    always_comb begin
        for (int i = 0; i < NBANKS; i++) begin
            state_d[i] = state_q[i];
            row_d[i]   = row_q[i];
            tmr_d[i]   = tmr_q[i];
            ras_d[i]   = ras_q[i];
        end
        burst_valid_d = burst_valid_q;
        burst_wr_d    = burst_wr_q;
        burst_beat_d  = burst_beat_q;
        burst_bank_d  = burst_bank_q;
        cmd_err_d     = any_cmd && !(acc_act || acc_rw || acc_pre);

        if (!halt) begin
            for (int i = 0; i < NBANKS; i++) begin
                if (ras_q[i] != RW'(T_RAS)) begin
                    ras_d[i] = ras_q[i] + RW'(1);
                end
                case (state_q[i])
                    S_ACTIVATING: begin
                        if (tmr_q[i] == TW'(T_RCD - 1)) begin
                            state_d[i] = S_ACTIVE;
                            tmr_d[i]   = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TW'(1);
                        end
                    end
                    S_PRECHARGING: begin
                        if (tmr_q[i] == TW'(T_RP - 1)) begin
                            state_d[i] = S_IDLE;
                            tmr_d[i]   = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end

            if (burst_valid_q) begin
                if (burst_beat_q == BEATW'(BL - 1)) begin
                    burst_valid_d          = 1'b0;
                    burst_beat_d           = '0;
                    state_d[burst_bank_q]  = S_ACTIVE;
                end else begin
                    burst_beat_d = burst_beat_q + BEATW'(1);
                end
            end

            // Accepted commands only touch a bank whose timer/burst logic above left it alone.
            if (acc_act) begin
                state_d[bank_idx] = S_ACTIVATING;
                row_d[bank_idx]   = row;
                tmr_d[bank_idx]   = '0;
                ras_d[bank_idx]   = '0;
            end
            if (acc_rw) begin
                state_d[bank_idx] = cmd_rd ? S_READING : S_WRITING;
                burst_valid_d     = 1'b1;
                burst_beat_d      = '0;
                burst_bank_d      = bank_idx;
                burst_wr_d        = cmd_wr;
            end
            if (acc_pre) begin
                state_d[bank_idx] = S_PRECHARGING;
                tmr_d[bank_idx]   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NBANKS; i++) begin
                state_q[i] <= S_IDLE;
                row_q[i]   <= '0;
                tmr_q[i]   <= '0;
                ras_q[i]   <= '0;
            end
            burst_valid_q <= 1'b0;
            burst_wr_q    <= 1'b0;
            burst_beat_q  <= '0;
            burst_bank_q  <= '0;
            cmd_err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NBANKS; i++) begin
                state_q[i] <= state_d[i];
                row_q[i]   <= row_d[i];
                tmr_q[i]   <= tmr_d[i];
                ras_q[i]   <= ras_d[i];
            end
            burst_valid_q <= burst_valid_d;
            burst_wr_q    <= burst_wr_d;
            burst_beat_q  <= burst_beat_d;
            burst_bank_q  <= burst_bank_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    logic [NBANKS-1:0] idle_vec;
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_idle
        assign idle_vec[gi] = (state_q[gi] == S_IDLE);
    end

    assign all_idle    = &idle_vec;
    assign bank_state  = state_q[bank_idx];
    assign open_row    = row_q[bank_idx];
    assign burst_valid = burst_valid_q;
    assign burst_wr    = burst_wr_q;
    assign burst_beat  = burst_beat_q;
    assign burst_bank  = burst_bank_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_dram_bank_timing_fsm.sv
// Bench for dram_bank_timing_fsm: directed scenarios plus random command traffic, all checked
// against a timestamp-based model (bank phases measured in non-halted edges since the command).
module tb_dram_bank_timing_fsm;

    localparam int BGW = 2, BAW = 2, AW = 17, BL = 8, T_RCD = 4, T_RAS = 10, T_RP = 4;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          halt = 1'b0, cmd_act = 1'b0, cmd_rd = 1'b0, cmd_wr = 1'b0, cmd_pre = 1'b0;
    logic [BGW-1:0] bg = '0;
    logic [BAW-1:0] ba = '0;
    logic [AW-1:0]  row = '0;
    logic [2:0]     bank_state;
    logic [AW-1:0]  open_row;
    logic           all_idle, burst_valid, burst_wr, cmd_err;
    logic [2:0]     burst_beat;
    logic [3:0]     burst_bank;

    dram_bank_timing_fsm #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .BL(BL),
        .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .halt(halt),
        .cmd_act(cmd_act), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_pre(cmd_pre),
        .bg(bg), .ba(ba), .row(row),
        .bank_state(bank_state), .open_row(open_row), .all_idle(all_idle),
        .burst_valid(burst_valid), .burst_wr(burst_wr), .burst_beat(burst_beat),
        .burst_bank(burst_bank), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Model: phase 0 closed, 1 opened by ACT, 2 closed by PRE; times are counts of non-halted edges.
    int          run;
    int          ph [NB];
    int          stamp [NB];
    int          act_stamp [NB];
    logic [AW-1:0] mrow [NB];
    bit          b_have, b_wr, m_err;
    int          b_start, b_bank;

    int n_vec = 0, n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;

    function automatic bit m_burst(input int r);
        return b_have && (r - b_start) < BL;
    endfunction

    function automatic int m_state(input int b, input int r);
        if (ph[b] == 1) begin
            if (r - stamp[b] < T_RCD) return 1;
            if (m_burst(r) && b_bank == b) return b_wr ? 4 : 3;
            return 2;
        end
        if (ph[b] == 2 && (r - stamp[b] < T_RP)) return 5;
        return 0;
    endfunction

    task automatic model_reset();
        run = 0;
        for (int i = 0; i < NB; i++) begin
            ph[i] = 0; stamp[i] = 0; act_stamp[i] = 0; mrow[i] = '0;
        end
        b_have = 0; b_wr = 0; b_start = 0; b_bank = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit a, input bit rd, input bit wr, input bit pr,
                              input bit h, input int b, input logic [AW-1:0] r_in);
        int  r, n, st;
        bit  acc;
        r   = run;
        n   = int'(a) + int'(rd) + int'(wr) + int'(pr);
        st  = m_state(b, r);
        acc = 0;
        if (!h && n == 1) begin
            if (a && st == 0) begin
                acc = 1; ph[b] = 1; stamp[b] = r + 1; act_stamp[b] = r + 1; mrow[b] = r_in;
            end else if ((rd || wr) && st == 2 && !m_burst(r)) begin
                acc = 1; b_have = 1; b_start = r + 1; b_bank = b; b_wr = wr;
            end else if (pr && st == 2 && (r + 1 - act_stamp[b]) >= T_RAS) begin
                acc = 1; ph[b] = 2; stamp[b] = r + 1;
            end
        end
        m_err = (n != 0) && !acc;
        if (!h) run = run + 1;
    endtask

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            int idx, beat;
            bit idle, bv;
            idx  = int'({bg, ba});
            idle = 1;
            for (int i = 0; i < NB; i++) if (m_state(i, run) != 0) idle = 0;
            bv   = m_burst(run);
            beat = bv ? (run - b_start) : 0;
            cmp("bank_state", 32'(bank_state), 32'(m_state(idx, run)));
            cmp("open_row", 32'(open_row), 32'(mrow[idx]));
            cmp("all_idle", 32'(all_idle), 32'(idle));
            cmp("burst_valid", 32'(burst_valid), 32'(bv));
            cmp("burst_beat", 32'(burst_beat), 32'(beat));
            cmp("burst_bank", 32'(burst_bank), 32'(b_bank));
            cmp("burst_wr", 32'(burst_wr), 32'(b_wr));
            cmp("cmd_err", 32'(cmd_err), 32'(m_err));
        end
    end

    task automatic step(input bit a, input bit rd, input bit wr, input bit pr,
                        input bit h, input int b, input logic [AW-1:0] r_in);
        cmd_act = a; cmd_rd = rd; cmd_wr = wr; cmd_pre = pr; halt = h;
        bg = BGW'(b >> BAW); ba = BAW'(b); row = r_in;
        @(posedge clk);
        model_edge(a, rd, wr, pr, h, b, r_in);
        n_vec++;
        #1;
        $display("vec %0d: act=%0b rd=%0b wr=%0b pre=%0b halt=%0b bank=%0d -> state=%0d err=%0b bv=%0b beat=%0d",
                 n_vec, a, rd, wr, pr, h, b, bank_state, cmd_err, burst_valid, burst_beat);
    endtask

    task automatic idle_steps(input int n, input int b);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, b, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cmd_act = 0; cmd_rd = 0; cmd_wr = 0; cmd_pre = 0; halt = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int  p, b;
        bit  a, rd, wr, pr, h;
        model_reset();
        do_reset();
        chk_en = 1'b1;
        bg = 2'd1; ba = 2'd1;
        #1;
        cmp("reset_state", 32'(bank_state), 32'd0);
        cmp("reset_all_idle", 32'(all_idle), 32'd1);
        cmp("reset_burst_valid", 32'(burst_valid), 32'd0);
        cmp("reset_cmd_err", 32'(cmd_err), 32'd0);

        // ACT bank 5 at edge 0: ACTIVATING through edge 3, ACTIVE at edge 4.
        step(1, 0, 0, 0, 0, 5, 17'h1A);
        idle_steps(3, 5);
        cmp("act_still_activating", 32'(bank_state), 32'd1);
        idle_steps(1, 5);
        cmp("act_active", 32'(bank_state), 32'd2);
        cmp("act_open_row", 32'(open_row), 32'h1A);
        cmp("act_no_err", 32'(cmd_err), 32'd0);
        step(0, 0, 0, 1, 0, 5, '0);                 // edge 5: tRAS not yet met
        cmp("early_pre_err", 32'(cmd_err), 32'd1);
        cmp("early_pre_state", 32'(bank_state), 32'd2);

        step(0, 0, 1, 0, 0, 5, '0);                 // WR at edge 6
        cmp("wr_valid", 32'(burst_valid), 32'd1);
        cmp("wr_beat0", 32'(burst_beat), 32'd0);
        cmp("wr_flag", 32'(burst_wr), 32'd1);
        cmp("wr_bank", 32'(burst_bank), 32'd5);
        idle_steps(7, 5);
        cmp("wr_beat7", 32'(burst_beat), 32'd7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, '0);  // RD on the final-beat edge
        cmp("b2b_rd_err", 32'(cmd_err), 32'd1);
        cmp("b2b_burst_done", 32'(burst_valid), 32'd0);
        cmp("b2b_state_active", 32'(bank_state), 32'd2);
        step(0, 1, 0, 0, 0, 5, '0);                 // one edge later: accepted
        cmp("rd_accept_err", 32'(cmd_err), 32'd0);
        cmp("rd_accept_state", 32'(bank_state), 32'd3);
        cmp("rd_accept_wr", 32'(burst_wr), 32'd0);
        idle_steps(8, 5);
        step(0, 0, 0, 1, 0, 5, '0);
        cmp("pre_state", 32'(bank_state), 32'd5);
        idle_steps(3, 5);
        cmp("pre_still", 32'(bank_state), 32'd5);
        idle_steps(1, 5);
        cmp("pre_idle", 32'(bank_state), 32'd0);
        cmp("pre_all_idle", 32'(all_idle), 32'd1);
        cmp("pre_row_kept", 32'(open_row), 32'h1A);

        // Halt: 3 frozen edges push ACTIVE out to 7 edges after ACT.
        step(1, 0, 0, 0, 0, 0, 17'h155);
        step(0, 0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 1, 0, '0);
        step(1, 0, 0, 0, 1, 1, 17'h7);
        cmp("halt_act_err", 32'(cmd_err), 32'd1);
        cmp("halt_bank1_idle", 32'(bank_state), 32'd0);
        step(0, 0, 0, 0, 1, 0, '0);
        idle_steps(2, 0);
        cmp("halt_still_activating", 32'(bank_state), 32'd1);
        idle_steps(1, 0);
        cmp("halt_active", 32'(bank_state), 32'd2);

        step(1, 1, 0, 0, 0, 2, 17'h3);
        cmp("multi_cmd_err", 32'(cmd_err), 32'd1);
        cmp("multi_cmd_state", 32'(bank_state), 32'd0);
        step(1, 0, 0, 0, 0, 0, 17'h9);
        cmp("act_on_active_err", 32'(cmd_err), 32'd1);
        cmp("act_on_active_row", 32'(open_row), 32'h155);

        for (int i = 0; i < 1500; i++) begin
            p  = int'($urandom_range(99));
            b  = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(3));
            a  = 0; rd = 0; wr = 0; pr = 0;
            if (p < 15) a = 1;
            else if (p < 27) rd = 1;
            else if (p < 39) wr = 1;
            else if (p < 52) pr = 1;
            else if (p < 55) begin a = 1; pr = 1; end
            h = ($urandom_range(9) == 0);
            step(a, rd, wr, pr, h, b, AW'($urandom));
        end

        // Asynchronous reset mid-burst at beat 3.
        do_reset();
        step(1, 0, 0, 0, 0, 3, 17'h44);
        idle_steps(4, 3);
        step(0, 1, 0, 0, 0, 3, '0);
        idle_steps(3, 3);
        cmp("pre_reset_beat3", 32'(burst_beat), 32'd3);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        cmp("async_rst_valid", 32'(burst_valid), 32'd0);
        cmp("async_rst_all_idle", 32'(all_idle), 32'd1);
        cmp("async_rst_state", 32'(bank_state), 32'd0);
        cmp("async_rst_beat", 32'(burst_beat), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1, 0, 0, 0, 0, 5, 17'h1A);
        idle_steps(3, 5);
        cmp("post_rst_activating", 32'(bank_state), 32'd1);
        idle_steps(1, 5);
        cmp("post_rst_active", 32'(bank_state), 32'd2);
        cmp("post_rst_row", 32'(open_row), 32'h1A);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
